// File: rtl/sprite_update_scheduler.sv
// Sprite update scheduler: buffers processor sprite-position commands in a
// small FIFO and commits them to the sprite attribute table only while the
// display is in vertical blank. Also stalls the processor for WAIT_VSYNC
// until the queued updates have been written.
module sprite_update_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int COORD_WIDTH = 10,
  parameter int ID_WIDTH    = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_code,
  input  logic [ID_WIDTH-1:0]    cmd_sprite_id,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic                   vblank,
  output logic                   sprite_we,
  output logic [ID_WIDTH-1:0]    sprite_id,
  output logic [COORD_WIDTH-1:0] sprite_x,
  output logic [COORD_WIDTH-1:0] sprite_y,
  output logic                   processor_stall,
  output logic                   cmd_error,
  output logic [7:0]             frame_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_WIDTH + 2 * COORD_WIDTH;

  localparam logic [4:0]       CODE_SPRITE_POS = 5'b00010;
  localparam logic [4:0]       CODE_WAIT_VSYNC = 5'b00110;
  localparam logic [CNT_W-1:0] DEPTH_CNT       = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               vblank_d;

  logic fifo_empty, fifo_full;
  logic accept, is_pos, is_wait, push, pop, illegal, vblank_rise;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_CNT);

  // Ready is held low while reset is asserted so nothing is offered as
  // accepted before the block has come out of reset.
  assign cmd_ready   = !reset && (state == S_IDLE) && !fifo_full;
  assign accept      = cmd_valid && cmd_ready;
  assign is_pos      = (cmd_code == CODE_SPRITE_POS);
  assign is_wait     = (cmd_code == CODE_WAIT_VSYNC);
  assign push        = accept && is_pos;
  assign illegal     = accept && !is_pos && !is_wait;
  assign vblank_rise = vblank && !vblank_d;

  // Entries leave the queue only in vblank, and never while WAIT is still
  // waiting for the vblank rising edge.
  assign pop = vblank && !fifo_empty && ((state == S_IDLE) || (state == S_DRAIN));

  assign processor_stall = (state != S_IDLE);

  // Next-state decode for the command/drain controller.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept && is_wait) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (vblank_rise) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty || !vblank) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, vblank edge detector and frame counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      vblank_d    <= 1'b0;
      frame_count <= 8'd0;
      cmd_error   <= 1'b0;
    end else begin
      state     <= state_nxt;
      vblank_d  <= vblank;
      cmd_error <= illegal;
      if (vblank_rise) frame_count <= frame_count + 8'd1;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the
  // count unchanged while both pointers advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_sprite_id, cmd_x, cmd_y};
  end

  // Registered sprite table write port: one strobe per popped entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sprite_we <= 1'b0;
      sprite_id <= '0;
      sprite_x  <= '0;
      sprite_y  <= '0;
    end else begin
      sprite_we <= pop;
      if (pop) {sprite_id, sprite_x, sprite_y} <= fifo_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Directed bench for sprite_update_scheduler with a write scoreboard.
module tb_sprite_update_scheduler;

  localparam int DEPTH = 4;
  localparam int CW    = 10;
  localparam int IW    = 5;
  localparam logic [4:0] POS  = 5'b00010;
  localparam logic [4:0] WVS  = 5'b00110;
  localparam logic [4:0] BAD  = 5'b00101;

  logic          clock, reset;
  logic          cmd_valid, cmd_ready;
  logic [4:0]    cmd_code;
  logic [IW-1:0] cmd_sprite_id;
  logic [CW-1:0] cmd_x, cmd_y;
  logic          vblank;
  logic          sprite_we;
  logic [IW-1:0] sprite_id;
  logic [CW-1:0] sprite_x, sprite_y;
  logic          processor_stall, cmd_error;
  logic [7:0]    frame_count;

  sprite_update_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .COORD_WIDTH(CW),
    .ID_WIDTH   (IW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_code       (cmd_code),
    .cmd_sprite_id  (cmd_sprite_id),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .vblank         (vblank),
    .sprite_we      (sprite_we),
    .sprite_id      (sprite_id),
    .sprite_x       (sprite_x),
    .sprite_y       (sprite_y),
    .processor_stall(processor_stall),
    .cmd_error      (cmd_error),
    .frame_count    (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  int base;
  logic [7:0] exp_frame = 8'd0;
  logic [IW+2*CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe is compared against the oldest expected entry.
  always @(negedge clock) begin
    if (sprite_we === 1'b1) begin
      n_writes++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("write_data", 64'({sprite_id, sprite_x, sprite_y}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives vblank for the next edge and tracks the expected frame count.
  task automatic set_vblank(input logic v);
    if (v && !vblank) exp_frame = exp_frame + 8'd1;
    vblank = v;
  endtask

  task automatic send(input logic [4:0] code, input int id, input int x, input int y);
    cmd_valid     = 1'b1;
    cmd_code      = code;
    cmd_sprite_id = IW'(id);
    cmd_x         = CW'(x);
    cmd_y         = CW'(y);
    check("send_ready", 64'(cmd_ready), 64'd1);
    if (cmd_ready && code == POS) exp_q.push_back({IW'(id), CW'(x), CW'(y)});
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vblank = 1'b0; cmd_valid = 1'b0;
    cmd_code = 5'd0; cmd_sprite_id = '0; cmd_x = '0; cmd_y = '0;
    #1;
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_stall", 64'(processor_stall), 64'd0);
    check("rst_we", 64'(sprite_we), 64'd0);
    check("rst_frame", 64'(frame_count), 64'd0);
    check("rst_err", 64'(cmd_error), 64'd0);
    check("rst_data", 64'({sprite_id, sprite_x, sprite_y}), 64'd0);
    #21 reset = 1'b0;
    #1 check("ready_after_rst", 64'(cmd_ready), 64'd1);
    tick();

    // Basic commit
    send(POS, 3, 100, 50);
    check("basic_no_err", 64'(cmd_error), 64'd0);
    tick(2);
    check("basic_no_early_we", 64'(sprite_we), 64'd0);
    set_vblank(1'b1);
    tick();
    check("basic_we", 64'(sprite_we), 64'd1);
    check("basic_data", 64'({sprite_id, sprite_x, sprite_y}), 64'({5'd3, 10'd100, 10'd50}));
    tick();
    check("basic_we_once", 64'(sprite_we), 64'd0);
    check("basic_writes", 64'(n_writes), 64'd1);
    check("basic_frame", 64'(frame_count), 64'(exp_frame));
    set_vblank(1'b0);
    tick();

    // Full FIFO
    for (int i = 0; i < DEPTH; i++) send(POS, 10 + i, 200 + i, 300 + i);
    check("full_ready_low", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_code = POS; cmd_sprite_id = IW'(20); cmd_x = CW'(7); cmd_y = CW'(9);
    tick(2);
    check("full_still_low", 64'(cmd_ready), 64'd0);
    check("full_no_we", 64'(sprite_we), 64'd0);
    set_vblank(1'b1);
    tick();
    check("full_we1", 64'(sprite_we), 64'd1);
    check("full_ready_after_pop", 64'(cmd_ready), 64'd1);
    if (cmd_ready) exp_q.push_back({IW'(20), CW'(7), CW'(9)});
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("full_we_run", 64'(sprite_we), 64'd1);
      tick();
    end
    check("full_we_end", 64'(sprite_we), 64'd0);
    check("full_writes", 64'(n_writes), 64'd6);
    set_vblank(1'b0);
    tick();

    // WAIT_VSYNC with two queued entries
    send(POS, 1, 11, 12);
    send(POS, 2, 21, 22);
    send(WVS, 0, 0, 0);
    check("wait_stall", 64'(processor_stall), 64'd1);
    check("wait_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1; cmd_code = POS; cmd_sprite_id = IW'(30); cmd_x = '0; cmd_y = '0;
    tick(9);
    check("wait_stall_hold", 64'(processor_stall), 64'd1);
    check("wait_no_drain", 64'(n_writes), 64'd6);
    set_vblank(1'b1);
    tick();
    check("wait_r_stall", 64'(processor_stall), 64'd1);
    check("wait_r_no_we", 64'(sprite_we), 64'd0);
    tick();
    check("wait_r1_we", 64'(sprite_we), 64'd1);
    check("wait_r1_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("wait_r2_we", 64'(sprite_we), 64'd1);
    check("wait_r2_stall", 64'(processor_stall), 64'd1);
    cmd_valid = 1'b0;
    tick();
    check("wait_r3_stall", 64'(processor_stall), 64'd0);
    check("wait_r3_we", 64'(sprite_we), 64'd0);
    check("wait_frame", 64'(frame_count), 64'(exp_frame));
    set_vblank(1'b0);
    tick();

    // Vblank ends mid-drain
    base = n_writes;
    for (int i = 0; i < DEPTH; i++) send(POS, 4 + i, 40 + i, 60 + i);
    set_vblank(1'b1);
    tick(2);
    set_vblank(1'b0);
    tick(3);
    check("mid_two_writes", 64'(n_writes - base), 64'd2);
    set_vblank(1'b1);
    tick(2);
    set_vblank(1'b0);
    tick(2);
    check("mid_rest_writes", 64'(n_writes - base), 64'd4);
    check("mid_frame", 64'(frame_count), 64'(exp_frame));

    // Illegal code
    base = n_writes;
    send(BAD, 7, 1, 2);
    check("ill_err", 64'(cmd_error), 64'd1);
    check("ill_stall", 64'(processor_stall), 64'd0);
    tick();
    check("ill_err_pulse", 64'(cmd_error), 64'd0);
    set_vblank(1'b1);
    tick(2);
    set_vblank(1'b0);
    tick();
    check("ill_no_write", 64'(n_writes - base), 64'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) send(POS, 12 + i, 5 + i, 6 + i);
    send(WVS, 0, 0, 0);
    tick(2);
    set_vblank(1'b1);
    tick();
    tick();
    check("rdr_we", 64'(sprite_we), 64'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check("rdr_we0", 64'(sprite_we), 64'd0);
    check("rdr_stall0", 64'(processor_stall), 64'd0);
    check("rdr_ready0", 64'(cmd_ready), 64'd0);
    check("rdr_frame0", 64'(frame_count), 64'd0);
    check("rdr_data0", 64'({sprite_id, sprite_x, sprite_y}), 64'd0);
    exp_q.delete();
    base = n_writes;
    tick();
    #2 reset = 1'b0;
    exp_frame = 8'd1;
    #1 check("rdr_ready_rel", 64'(cmd_ready), 64'd1);
    tick();
    check("rdr_first_rise", 64'(frame_count), 64'(exp_frame));
    tick(3);
    check("rdr_empty", 64'(n_writes - base), 64'd0);
    set_vblank(1'b0);
    tick();

    // Frame counter wrap
    for (int i = 0; i < 256; i++) begin
      set_vblank(1'b1);
      tick();
      set_vblank(1'b0);
      tick();
      if (i == 254) check("wrap_zero", 64'(frame_count), 64'(exp_frame));
    end
    check("wrap_full", 64'(frame_count), 64'(exp_frame));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
